random_delay_gen: RTL and testbench
===================================

# random_delay_gen

Random-interval generator that sits directly upstream of the game-control FSM and drives that FSM's `lfsr_begin` input. A free-running 16-bit LFSR supplies entropy. Each time the FSM releases `lfsr_reset`, the block captures a random delay, counts it out in prescaled ticks, and then emits a single-cycle `lfsr_begin` pulse. It stays quiet until the FSM re-arms it by asserting `lfsr_reset` again.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clocks per delay tick (1 ms at 50 MHz); must be ≥ 1.
- `MIN_DELAY`, default 1000: fixed delay floor, in ticks; must be ≥ 1.
- `RANGE_BITS`, default 12: number of LFSR bits added to the floor (1..16).
- `SEED`, default 16'hACE1: LFSR value at reset; must be nonzero.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `lfsr_reset`  in  1  synchronous timer clear/hold from the FSM; level-sensitive.
- `lfsr_begin`  out  1  one-cycle pulse when the delay expires.
- `busy`  out  1  high while a delay is loading or counting.
- `delay_value`  out  DW  last captured delay in ticks, where DW = $clog2(MIN_DELAY + 2**RANGE_BITS).

## Operation
- **LFSR**
  - Reset value is `SEED`.
  - Advances every clock, independent of `lfsr_reset` and of state.
  - Update: fb = l[0]^l[2]^l[3]^l[5]; l <= {fb, l[15:1]}.
  - If l == 0, load `SEED` next cycle (defensive lock-up escape).
- **State machine: IDLE, LOAD, COUNT, DONE**
  - **IDLE:** outputs quiet. If `lfsr_reset` = 0, go to LOAD.
  - **LOAD:**
    - delay_cnt <= MIN_DELAY + l[RANGE_BITS-1:0], zero-extended to DW bits. The captured value is the LFSR register value before this edge's update.
    - `delay_value` <= same value.
    - presc <= TICK_DIV-1.
    - Go to COUNT.
  - **COUNT:** each clock:
    - If presc == 0: presc <= TICK_DIV-1 and delay_cnt <= delay_cnt-1.
    - Else: presc <= presc-1.
    - If presc == 0 and delay_cnt == 1: go to DONE and register `lfsr_begin` = 1.
  - **DONE:** `lfsr_begin` = 0 after its single cycle. Remain in DONE until `lfsr_reset` = 1, then go to IDLE.
- **`lfsr_reset` = 1 in any state** (LOAD, COUNT or DONE) → IDLE on the next edge.
  - Counters clear; the LFSR is not affected.
  - A pending expiry in the same cycle is discarded: no pulse.
  - `lfsr_reset` takes priority over every other transition.
- **Arithmetic:** unsigned. No overflow by construction, since the maximum is MIN_DELAY + 2**RANGE_BITS - 1 < 2**DW.
- **Outputs:** `busy` = (state == LOAD || state == COUNT).

## Timing
- **Reset values:**
  - state = IDLE, LFSR = SEED.
  - `lfsr_begin` = 0, `busy` = 0, `delay_value` = 0.
  - presc and delay_cnt = 0.
- **Latency:** let E0 be the edge at which IDLE samples `lfsr_reset` = 0. E1 is the LOAD edge. `lfsr_begin` goes high after edge E1 + D·TICK_DIV and stays high for exactly one clock.
- **Pulse count:** at most one pulse per `lfsr_reset` release; no retrigger from DONE.
- **Async reset:** `reset_n` low mid-count aborts immediately. All outputs return to their reset values without waiting for a clock.
- **TICK_DIV = 1:** presc is held at 0 and every COUNT cycle is a tick.

## Structure
- Shared package `game_pkg`:
  - Typedef `delay_state_t` {IDLE, LOAD, COUNT, DONE}.
  - LFSR tap constant.
  - `DEFAULT_SEED`.
- Sub-module `lfsr16` (clk, reset_n, seed, q): free-running, with the zero-escape built in.
- Prescaler and down-counter live inline in `random_delay_gen`.

## Test plan
Unless a case says otherwise, parameters are TICK_DIV=4, MIN_DELAY=2, RANGE_BITS=4, SEED=16'hACE1.
- **LFSR sequence:** release `reset_n` with `lfsr_reset`=1 → LFSR = 16'h5670 after the 1st edge and 16'hAB38 after the 2nd; `busy`=0 and no pulse.
- **Delay from first LFSR value:** `lfsr_reset`=0 from reset release → LOAD captures 16'h5670 → `delay_value`=2, and `lfsr_begin` pulses once, 8 clocks after the LOAD edge.
- **Delay from second LFSR value:** release `lfsr_reset` one cycle later → captures 16'hAB38 → `delay_value`=10, pulse 40 clocks after the LOAD edge, `busy` high throughout.
- **Abort mid-count:** assert `lfsr_reset` during COUNT at cycle 5 → IDLE next edge, `busy`=0, and no pulse ever for that run.
- **No retrigger:** hold `lfsr_reset`=0 for 200 cycles after a pulse → exactly one pulse. Then pulse `lfsr_reset` high for 1 cycle → a new delay runs and a second pulse occurs.
- **Async reset mid-count:** drop `reset_n` mid-count, between clock edges → outputs are 0 immediately, LFSR = 16'hACE1, state IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the random delay generator
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } delay_state_t;

    // Feedback taps l[0]^l[2]^l[3]^l[5] as a mask over the 16-bit register.
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/random_delay_gen_if.sv
// rtl/random_delay_gen_if.sv - control/status bundle between game FSM and delay generator
//
// lfsr_reset  : FSM -> generator, level-sensitive clear/hold
// lfsr_begin  : generator -> FSM, one-cycle expiry pulse
// busy        : generator -> FSM, high while loading or counting
// delay_value : generator -> FSM, last captured delay in ticks
interface random_delay_gen_if #(
    parameter int DW = 13
);
    logic          lfsr_reset;
    logic          lfsr_begin;
    logic          busy;
    logic [DW-1:0] delay_value;

    modport master (
        output lfsr_reset,
        input  lfsr_begin,
        input  busy,
        input  delay_value
    );

    modport slave (
        input  lfsr_reset,
        output lfsr_begin,
        output busy,
        output delay_value
    );

endinterface

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR with zero lock-up escape
//
// clk     : rising-edge clock
// reset_n : asynchronous active-low reset, loads seed
// seed    : reset / escape value, must be nonzero
// q       : current register value
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= seed;
        end else if (q == 16'h0000) begin
            // All-zero is a fixed point of the XOR feedback; reseed to escape it.
            q <= seed;
        end else begin
            q <= {^(q & LFSR_TAPS), q[15:1]};
        end
    end

endmodule

// File: rtl/random_delay_gen.sv
// rtl/random_delay_gen.sv - random-interval generator driving the game FSM start pulse
//
// clk     : rising-edge clock
// reset_n : asynchronous active-low reset
// bus     : slave side of random_delay_gen_if (lfsr_reset in; lfsr_begin, busy, delay_value out)
module random_delay_gen
    import game_pkg::*;
#(
    parameter int          TICK_DIV   = 50000,
    parameter int          MIN_DELAY  = 1000,
    parameter int          RANGE_BITS = 12,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            reset_n,
    random_delay_gen_if.slave bus
);

    localparam int DW = $clog2(MIN_DELAY + 2**RANGE_BITS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] MIN_W     = DW'(MIN_DELAY);

    delay_state_t  state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [DW-1:0] delay_cnt, delay_cnt_n;
    logic [DW-1:0] delay_value, delay_value_n;
    logic          begin_q, begin_n;
    logic          busy;
    logic [15:0]   lfsr_q;
    logic [DW-1:0] load_val;
    logic          unused_lfsr;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (SEED),
        .q       (lfsr_q)
    );

    // Only the low RANGE_BITS feed the delay; the rest just keep the sequence long.
    assign unused_lfsr = ^lfsr_q;

    // MIN_DELAY >= 1 guarantees DW > RANGE_BITS, so the pad width is positive.
    assign load_val = MIN_W + {{(DW-RANGE_BITS){1'b0}}, lfsr_q[RANGE_BITS-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            presc       <= '0;
            delay_cnt   <= '0;
            delay_value <= '0;
            begin_q     <= 1'b0;
        end else begin
            state       <= state_n;
            presc       <= presc_n;
            delay_cnt   <= delay_cnt_n;
            delay_value <= delay_value_n;
            begin_q     <= begin_n;
        end
    end

    always_comb begin
        state_n       = state;
        presc_n       = presc;
        delay_cnt_n   = delay_cnt;
        delay_value_n = delay_value;
        begin_n       = 1'b0;
        busy          = (state == LOAD) || (state == COUNT);

        case (state)
            IDLE: begin
                if (!bus.lfsr_reset) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                delay_cnt_n   = load_val;
                delay_value_n = load_val;
                presc_n       = PRESC_MAX;
                state_n       = COUNT;
            end
            COUNT: begin
                if (presc == '0) begin
                    presc_n     = PRESC_MAX;
                    delay_cnt_n = delay_cnt - DW'(1);
                    if (delay_cnt == DW'(1)) begin
                        state_n = DONE;
                        begin_n = 1'b1;
                    end
                end else begin
                    presc_n = presc - PW'(1);
                end
            end
            DONE: begin
                // Parked until the FSM re-arms us; no retrigger from here.
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Clear/hold overrides everything, including an expiry in this same cycle.
        if (bus.lfsr_reset) begin
            state_n     = IDLE;
            presc_n     = '0;
            delay_cnt_n = '0;
            begin_n     = 1'b0;
        end
    end

    assign bus.lfsr_begin  = begin_q;
    assign bus.busy        = busy;
    assign bus.delay_value = delay_value;

endmodule

// File: tb/tb_random_delay_gen.sv
// tb/tb_random_delay_gen.sv - self-checking bench for random_delay_gen
module tb_random_delay_gen;
    import game_pkg::*;

    localparam int          TD   = 4;
    localparam int          MD   = 2;
    localparam int          RB   = 4;
    localparam int          DW   = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc       = 0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    random_delay_gen_if #(.DW(DW)) bus  ();
    random_delay_gen_if #(.DW(DW)) bus1 ();

    assign bus1.lfsr_reset = bus.lfsr_reset;

    random_delay_gen #(.TICK_DIV(TD), .MIN_DELAY(MD), .RANGE_BITS(RB), .SEED(SEED)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    random_delay_gen #(.TICK_DIV(1), .MIN_DELAY(MD), .RANGE_BITS(RB), .SEED(SEED)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic fb;
        if (v == 16'h0) return SEED;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    logic [15:0] lfsr_m;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_m <= SEED;
        else          lfsr_m <= lfsr_next(lfsr_m);
    end

    // Releases lfsr_reset at the current negedge and observes for `watch` cycles.
    // The captured LFSR value is the model value after the next edge (the IDLE edge E0).
    task automatic run_delay(input bit release_rst, input int abort_at, input int watch,
                             output int e1, output int d, output int np, output int fp,
                             output int np1, output int fp1, output int busy_err,
                             output logic [DW-1:0] dv);
        logic [15:0] cap;
        int e0;
        logic exp_busy;
        cap = lfsr_next(lfsr_m);
        d   = MD + int'(cap[RB-1:0]);
        e0  = cyc + 1;
        e1  = e0 + 1;
        np = 0; fp = -1; np1 = 0; fp1 = -1; busy_err = 0;
        if (release_rst) reset_n = 1'b1;
        bus.lfsr_reset = 1'b0;
        for (int k = 0; k < watch; k++) begin
            @(negedge clk);
            if (bus.lfsr_begin === 1'b1) begin
                np++;
                if (fp < 0) fp = cyc;
            end
            if (bus1.lfsr_begin === 1'b1) begin
                np1++;
                if (fp1 < 0) fp1 = cyc;
            end
            exp_busy = (cyc >= e0) && (cyc < e1 + d*TD) && (abort_at < 0 || cyc <= e1 + abort_at);
            if (bus.busy !== exp_busy) busy_err++;
            if (abort_at >= 0 && cyc == e1 + abort_at) bus.lfsr_reset = 1'b1;
        end
        dv = bus.delay_value;
    endtask

    int e1, d, np, fp, np1, fp1, berr;
    logic [DW-1:0] dv;

    task automatic test_reset();
        reset_n = 1'b0;
        bus.lfsr_reset = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.lfsr_begin !== 1'b0) $display("FAIL reset_begin: got %0b want 0", bus.lfsr_begin); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.delay_value !== 5'd0) $display("FAIL reset_delay_value: got %0d want 0", bus.delay_value); else pass_cnt++;
        total_cnt++; if (dut.u_lfsr.q !== SEED) $display("FAIL reset_lfsr: got %h want %h", dut.u_lfsr.q, SEED); else pass_cnt++;
        total_cnt++; if (dut.state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state); else pass_cnt++;
    endtask

    task automatic test_lfsr_sequence();
        int pulses;
        pulses = 0;
        reset_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (dut.u_lfsr.q !== 16'h5670) $display("FAIL lfsr_step1: got %h want 5670", dut.u_lfsr.q); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (dut.u_lfsr.q !== 16'hAB38) $display("FAIL lfsr_step2: got %h want ab38", dut.u_lfsr.q); else pass_cnt++;
        for (int k = 0; k < 20; k++) begin
            if (bus.lfsr_begin === 1'b1 || bus.busy === 1'b1) pulses++;
            @(negedge clk);
        end
        total_cnt++; if (pulses !== 0) $display("FAIL lfsr_held_quiet: got %0d active cycles want 0", pulses); else pass_cnt++;
        total_cnt++; if (dut.u_lfsr.q !== lfsr_m) $display("FAIL lfsr_free_run: got %h want %h", dut.u_lfsr.q, lfsr_m); else pass_cnt++;
    endtask

    task automatic test_first_value();
        reset_n = 1'b0;
        bus.lfsr_reset = 1'b0;
        repeat (2) @(negedge clk);
        run_delay(1'b1, -1, 60, e1, d, np, fp, np1, fp1, berr, dv);
        total_cnt++; if (dv !== 5'd2) $display("FAIL first_delay_value: got %0d want 2", dv); else pass_cnt++;
        total_cnt++; if (fp !== e1 + 8) $display("FAIL first_pulse_time: got %0d want %0d", fp, e1 + 8); else pass_cnt++;
        total_cnt++; if (np !== 1) $display("FAIL first_pulse_count: got %0d want 1", np); else pass_cnt++;
        total_cnt++; if (berr !== 0) $display("FAIL first_busy: got %0d bad cycles want 0", berr); else pass_cnt++;
        total_cnt++; if (fp1 !== e1 + 2 || np1 !== 1) $display("FAIL first_tick1: got pulse %0d x%0d want %0d x1", fp1, np1, e1 + 2); else pass_cnt++;
    endtask

    task automatic test_second_value();
        reset_n = 1'b0;
        bus.lfsr_reset = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_delay(1'b0, -1, 80, e1, d, np, fp, np1, fp1, berr, dv);
        total_cnt++; if (dv !== 5'd10) $display("FAIL second_delay_value: got %0d want 10", dv); else pass_cnt++;
        total_cnt++; if (fp !== e1 + 40) $display("FAIL second_pulse_time: got %0d want %0d", fp, e1 + 40); else pass_cnt++;
        total_cnt++; if (np !== 1) $display("FAIL second_pulse_count: got %0d want 1", np); else pass_cnt++;
        total_cnt++; if (berr !== 0) $display("FAIL second_busy: got %0d bad cycles want 0", berr); else pass_cnt++;
        total_cnt++; if (fp1 !== e1 + 10) $display("FAIL second_tick1: got %0d want %0d", fp1, e1 + 10); else pass_cnt++;
    endtask

    task automatic test_abort();
        bus.lfsr_reset = 1'b1;
        @(negedge clk);
        run_delay(1'b0, 5, 120, e1, d, np, fp, np1, fp1, berr, dv);
        total_cnt++; if (np !== 0) $display("FAIL abort_no_pulse: got %0d want 0", np); else pass_cnt++;
        total_cnt++; if (berr !== 0) $display("FAIL abort_busy: got %0d bad cycles want 0", berr); else pass_cnt++;
        total_cnt++; if (dut.state !== IDLE) $display("FAIL abort_state: got %0d want IDLE", dut.state); else pass_cnt++;
        total_cnt++; if (dv !== DW'(d)) $display("FAIL abort_delay_value: got %0d want %0d", dv, d); else pass_cnt++;
        total_cnt++; if (np1 !== ((5 >= d) ? 1 : 0)) $display("FAIL abort_tick1: got %0d want %0d", np1, (5 >= d) ? 1 : 0); else pass_cnt++;
    endtask

    task automatic test_abort_boundary();
        logic [15:0] nxt;
        int dd;
        // lfsr_reset rises on the very cycle the expiry would be registered: no pulse.
        @(negedge clk);
        nxt = lfsr_next(lfsr_m);
        dd  = MD + int'(nxt[RB-1:0]);
        run_delay(1'b0, dd*TD - 1, 100, e1, d, np, fp, np1, fp1, berr, dv);
        total_cnt++; if (np !== 0) $display("FAIL boundary_discard: got %0d want 0", np); else pass_cnt++;
        total_cnt++; if (berr !== 0) $display("FAIL boundary_discard_busy: got %0d bad cycles want 0", berr); else pass_cnt++;
        // One cycle later the pulse has already been registered and must survive.
        @(negedge clk);
        nxt = lfsr_next(lfsr_m);
        dd  = MD + int'(nxt[RB-1:0]);
        run_delay(1'b0, dd*TD, 100, e1, d, np, fp, np1, fp1, berr, dv);
        total_cnt++; if (np !== 1 || fp !== e1 + d*TD) $display("FAIL boundary_keep: got %0d at %0d want 1 at %0d", np, fp, e1 + d*TD); else pass_cnt++;
    endtask

    task automatic test_no_retrigger();
        @(negedge clk);
        run_delay(1'b0, -1, 300, e1, d, np, fp, np1, fp1, berr, dv);
        total_cnt++; if (np !== 1) $display("FAIL noretrig_count: got %0d want 1", np); else pass_cnt++;
        total_cnt++; if (fp !== e1 + d*TD) $display("FAIL noretrig_time: got %0d want %0d", fp, e1 + d*TD); else pass_cnt++;
        total_cnt++; if (dut.state !== DONE) $display("FAIL noretrig_state: got %0d want DONE", dut.state); else pass_cnt++;
        bus.lfsr_reset = 1'b1;
        @(negedge clk);
        run_delay(1'b0, -1, 100, e1, d, np, fp, np1, fp1, berr, dv);
        total_cnt++; if (np !== 1 || fp !== e1 + d*TD) $display("FAIL rearm_pulse: got %0d at %0d want 1 at %0d", np, fp, e1 + d*TD); else pass_cnt++;
        total_cnt++; if (dv !== DW'(d)) $display("FAIL rearm_delay_value: got %0d want %0d", dv, d); else pass_cnt++;
    endtask

    task automatic test_random();
        int abort_at, exp_np, exp_np1;
        for (int it = 0; it < 10; it++) begin
            bus.lfsr_reset = 1'b1;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            abort_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 80));
            run_delay(1'b0, abort_at, 100, e1, d, np, fp, np1, fp1, berr, dv);
            exp_np  = (abort_at < 0 || abort_at >= d*TD) ? 1 : 0;
            exp_np1 = (abort_at < 0 || abort_at >= d) ? 1 : 0;
            total_cnt++; if (np !== exp_np) $display("FAIL rand%0d_count: got %0d want %0d", it, np, exp_np); else pass_cnt++;
            if (exp_np == 1) begin
                total_cnt++; if (fp !== e1 + d*TD) $display("FAIL rand%0d_time: got %0d want %0d", it, fp, e1 + d*TD); else pass_cnt++;
            end
            total_cnt++; if (berr !== 0) $display("FAIL rand%0d_busy: got %0d bad cycles want 0", it, berr); else pass_cnt++;
            total_cnt++; if (dv !== DW'(d)) $display("FAIL rand%0d_delay_value: got %0d want %0d", it, dv, d); else pass_cnt++;
            total_cnt++; if (np1 !== exp_np1) $display("FAIL rand%0d_tick1: got %0d want %0d", it, np1, exp_np1); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        bus.lfsr_reset = 1'b1;
        @(negedge clk);
        bus.lfsr_reset = 1'b0;
        repeat (6) @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL async_pre_busy: got %0b want 1", bus.busy); else pass_cnt++;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL async_busy: got %0b want 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.lfsr_begin !== 1'b0) $display("FAIL async_begin: got %0b want 0", bus.lfsr_begin); else pass_cnt++;
        total_cnt++; if (bus.delay_value !== 5'd0) $display("FAIL async_delay_value: got %0d want 0", bus.delay_value); else pass_cnt++;
        total_cnt++; if (dut.u_lfsr.q !== SEED) $display("FAIL async_lfsr: got %h want %h", dut.u_lfsr.q, SEED); else pass_cnt++;
        total_cnt++; if (dut.state !== IDLE) $display("FAIL async_state: got %0d want IDLE", dut.state); else pass_cnt++;
    endtask

    initial begin
        bus.lfsr_reset = 1'b1;
        test_reset();
        test_lfsr_sequence();
        test_first_value();
        test_second_value();
        test_abort();
        test_abort_boundary();
        test_no_retrigger();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
